lcd_byte_writer: RTL
====================

Name: lcd_byte_writer

Overview:
- Bus-level write engine for the HD44780-compatible character LCD on the DE2 board.
- Sits directly downstream of the LCD message sequencer. It takes one byte plus RS per request, drives the LCD pins with correct setup, enable-pulse and hold timing, then reports completion.
- Write-only: LCD_RW is tied low.
- Timing defaults assume iCLK = 50 MHz.

Parameters:
SETUP_CYC, 2, cycles that LCD_DATA/LCD_RS are stable before LCD_EN rises (tAS ≥ 40 ns); must be ≥ 1
EN_CYC, 16, cycles LCD_EN stays high (PWEH ≥ 230 ns); must be ≥ 1
HOLD_CYC, 2, cycles that LCD_DATA/LCD_RS are held after LCD_EN falls (tAH ≥ 10 ns); must be ≥ 1
CMD_WAIT_CYC, 82000, post-write wait for clear/home commands (1.64 ms); used only with the optional feature
DATA_WAIT_CYC, 2000, post-write wait for all other writes (40 µs); used only with the optional feature

Ports:
iCLK  input  1  system clock
iRST_N  input  1  asynchronous active-low reset
iDATA  input  8  byte to write
iRS  input  1  register select: 0 = command, 1 = data
iStart  input  1  request; a write starts on its rising edge
oDone  output  1  one-cycle completion pulse
LCD_DATA  output  8  LCD data bus
LCD_RW  output  1  constant 0
LCD_EN  output  1  LCD enable strobe
LCD_RS  output  1  LCD register select

Behaviour:
- Reset is iRST_N, asynchronous, active-low; clock is iCLK.
- Values during reset: LCD_DATA = 0, LCD_RS = 0, LCD_EN = 0, LCD_RW = 0, oDone = 0, state = IDLE, counter = 0, start_q = 0.
- Edge detect:
  - start_q registers iStart every cycle.
  - A request is iStart & ~start_q, sampled only in IDLE.
  - If iStart is held high after a write completes, no new write starts; a fresh rising edge is required.
  - A rising edge outside IDLE is ignored. There is no queueing.
- State machine, with each transition taken on a clock edge:
  - IDLE: on a request, latch iDATA into LCD_DATA and iRS into LCD_RS; load the counter with SETUP_CYC-1; go to SETUP.
  - SETUP: when the counter reaches 0, set LCD_EN = 1, load EN_CYC-1, go to PULSE.
  - PULSE: when the counter reaches 0, set LCD_EN = 0, load HOLD_CYC-1, go to HOLD.
  - HOLD: when the counter reaches 0, go to DONE. With the optional feature, go to WAIT instead.
  - DONE: oDone = 1 for exactly this one cycle; return to IDLE.
- Latency: oDone is high exactly 1+SETUP_CYC+EN_CYC+HOLD_CYC cycles after the edge that samples the request. With defaults that is 21 cycles.
- LCD_EN is high for exactly EN_CYC consecutive cycles per write. LCD_EN is never high outside PULSE.
- LCD_DATA/LCD_RS change only on the IDLE→SETUP transition and keep their last value afterwards.
- The counter width is the clog2 of the largest active wait; it is 17 bits when the feature is enabled.
- Reset asserted mid-write: all outputs go to their reset values immediately (LCD_EN drops asynchronously). After reset release the block is in IDLE and needs a fresh rising edge of iStart.
- Compatibility with the sequencer: the sequencer holds iStart high until it sees oDone, then drops it. A back-to-back request needs iStart low for at least one cycle between writes.

Optional Feature:
- Macro: LCD_POST_DELAY_EN.
- Defined:
  - A WAIT state is inserted between HOLD and DONE.
  - If the latched RS == 0 and latched DATA[7:2] == 0 (clear 0x01, home 0x02/0x03), the wait is CMD_WAIT_CYC cycles.
  - Otherwise the wait is DATA_WAIT_CYC cycles.
  - oDone is then issued 1+SETUP_CYC+EN_CYC+HOLD_CYC+wait cycles after the request edge.
  - This lets the upstream sequencer drop its own inter-byte delay.
- Undefined: no WAIT state; the wait parameters are unused; timing is as in Behaviour.

Decomposition:
- Package lcd_pkg contains:
  - the state enum (IDLE, SETUP, PULSE, HOLD, WAIT, DONE);
  - default timing constants;
  - command codes: CLEAR 0x01, HOME 0x02, ENTRY 0x06, DISPLAY_ON 0x0C, FUNC_8BIT_2LINE 0x38, LINE1 0x80, LINE2 0xC0;
  - the is_slow_cmd(rs, data) helper.
- Sub-module lcd_cycle_timer: a loadable down-counter with a zero flag, shared by all timed states.

Test Plan:
- Reset then idle: iRST_N low for 3 cycles → all outputs 0; no LCD_EN activity for 100 cycles with iStart = 0.
- Single data write: iDATA = 0x59, iRS = 1, iStart rises → LCD_DATA = 0x59 and LCD_RS = 1 from the next cycle; LCD_EN rises 2 cycles later and stays high for 16 cycles; oDone pulses once, 21 cycles after the edge.
- Held start: iStart kept high for 200 cycles → exactly one LCD_EN pulse and one oDone. Dropping and then raising iStart again starts a second write with iDATA = 0x6F.
- Request while busy: a second iStart rising edge during PULSE (iStart pulsed low for 1 cycle, then high) → ignored; LCD_DATA is unchanged; exactly one oDone.
- Reset mid-pulse: assert iRST_N in PULSE cycle 5 → LCD_EN = 0 in the same cycle (asynchronous); after release, state is IDLE and there is no oDone.
- With LCD_POST_DELAY_EN: command 0x01 with RS = 0 → oDone at 21+82000 cycles. Data 0x41 with RS = 1 → oDone at 21+2000 cycles.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the DE2 character-LCD write path.
//   - lcd_state_e : write-engine state encoding
//   - DEF_*_CYC   : default timing in iCLK cycles (50 MHz)
//   - CMD_*       : common HD44780 command bytes
//   - is_slow_cmd : true for clear/home, which need the long settle time
//   - cnt_width   : counter width needed to hold values 0..n-1
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } lcd_state_e;

  localparam int unsigned DEF_SETUP_CYC     = 2;
  localparam int unsigned DEF_EN_CYC        = 16;
  localparam int unsigned DEF_HOLD_CYC      = 2;
  localparam int unsigned DEF_CMD_WAIT_CYC  = 82000;
  localparam int unsigned DEF_DATA_WAIT_CYC = 2000;

  localparam logic [7:0] CMD_CLEAR           = 8'h01;
  localparam logic [7:0] CMD_HOME            = 8'h02;
  localparam logic [7:0] CMD_ENTRY           = 8'h06;
  localparam logic [7:0] CMD_DISPLAY_ON      = 8'h0C;
  localparam logic [7:0] CMD_FUNC_8BIT_2LINE = 8'h38;
  localparam logic [7:0] CMD_LINE1           = 8'h80;
  localparam logic [7:0] CMD_LINE2           = 8'hC0;

  // Clear (0x01) and home (0x02/0x03) are the only commands with DATA[7:2] == 0.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return (!rs) && (data[7:2] == 6'd0);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lcd_byte_writer_if.sv
// lcd_byte_writer_if: request/completion handshake between the LCD message
// sequencer (master) and the byte write engine (slave).
//   iDATA  : byte to write
//   iRS    : register select, 0 = command, 1 = data
//   iStart : request, a write starts on its rising edge
//   oDone  : one-cycle completion pulse
interface lcd_byte_writer_if;
  logic [7:0] iDATA;
  logic       iRS;
  logic       iStart;
  logic       oDone;

  modport master (output iDATA, output iRS, output iStart, input oDone);
  modport slave  (input iDATA, input iRS, input iStart, output oDone);
endinterface

// File: rtl/lcd_cycle_timer.sv
// lcd_cycle_timer: loadable down-counter shared by every timed state.
//   iCLK, iRST_N : clock, async active-low reset
//   load_i       : load load_val_i this cycle (wins over counting)
//   load_val_i   : value to load; zero_o rises load_val_i cycles later
//   zero_o       : counter is at zero (it stops there)
module lcd_cycle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         iCLK,
  input  logic         iRST_N,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: writes one byte + RS to an HD44780 LCD with setup,
// enable-pulse and hold timing, then pulses oDone. Write-only (LCD_RW = 0).
//   iCLK, iRST_N : clock, async active-low reset
//   req          : sequencer handshake (iDATA, iRS, iStart in; oDone out)
//   LCD_DATA     : LCD data bus
//   LCD_RW       : constant 0
//   LCD_EN       : enable strobe, high for EN_CYC cycles per write
//   LCD_RS       : register select
// Optional build macro LCD_POST_DELAY_EN: adds a WAIT state after HOLD so the
// LCD's command execution time is covered before oDone is issued.
//
// state | meaning
// IDLE  | waiting for a rising edge on iStart
// SETUP | data/RS driven, EN low, SETUP_CYC cycles
// PULSE | EN high, EN_CYC cycles
// HOLD  | EN low, data/RS held, HOLD_CYC cycles
// WAIT  | post-write execution delay (LCD_POST_DELAY_EN only)
// DONE  | one cycle; oDone is registered from it
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC     = DEF_SETUP_CYC,
  parameter int unsigned EN_CYC        = DEF_EN_CYC,
  parameter int unsigned HOLD_CYC      = DEF_HOLD_CYC,
  parameter int unsigned CMD_WAIT_CYC  = DEF_CMD_WAIT_CYC,
  parameter int unsigned DATA_WAIT_CYC = DEF_DATA_WAIT_CYC
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  lcd_byte_writer_if.slave req,
  output logic [7:0]       LCD_DATA,
  output logic             LCD_RW,
  output logic             LCD_EN,
  output logic             LCD_RS
);

  if (SETUP_CYC < 1 || EN_CYC < 1 || HOLD_CYC < 1 ||
      CMD_WAIT_CYC < 1 || DATA_WAIT_CYC < 1) begin : g_bad_param
    $error("lcd_byte_writer: every cycle count must be at least 1");
  end

  localparam int unsigned BASE_MAX = max2(max2(SETUP_CYC, EN_CYC), HOLD_CYC);
`ifdef LCD_POST_DELAY_EN
  localparam int unsigned MAX_CYC  = max2(BASE_MAX, max2(CMD_WAIT_CYC, DATA_WAIT_CYC));
`else
  localparam int unsigned MAX_CYC  = BASE_MAX;
`endif
  localparam int unsigned CNT_W    = cnt_width(MAX_CYC);

  lcd_state_e       state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             start_q;
  logic             request;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  assign request = req.iStart & ~start_q;

  lcd_cycle_timer #(.W(CNT_W)) u_timer (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rs_d     = rs_q;
    en_d     = en_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE: if (request) begin
        data_d   = req.iDATA;
        rs_d     = req.iRS;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(SETUP_CYC - 1);
        state_d  = SETUP;
      end
      SETUP: if (tmr_zero) begin
        en_d     = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(EN_CYC - 1);
        state_d  = PULSE;
      end
      PULSE: if (tmr_zero) begin
        en_d     = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(HOLD_CYC - 1);
        state_d  = HOLD;
      end
      HOLD: if (tmr_zero) begin
`ifdef LCD_POST_DELAY_EN
        tmr_load = 1'b1;
        tmr_val  = is_slow_cmd(rs_q, data_q) ? CNT_W'(CMD_WAIT_CYC - 1)
                                             : CNT_W'(DATA_WAIT_CYC - 1);
        state_d  = WAIT;
`else
        state_d  = DONE;
`endif
      end
`ifdef LCD_POST_DELAY_EN
      WAIT: if (tmr_zero) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Registered from DONE so the pulse lands 1+SETUP+EN+HOLD(+wait) cycles
    // after the sampling edge.
    done_d = (state_q == DONE);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      done_q  <= done_d;
      start_q <= req.iStart;
    end
  end

  assign LCD_DATA  = data_q;
  assign LCD_RS    = rs_q;
  assign LCD_EN    = en_q;
  assign LCD_RW    = 1'b0;
  assign req.oDone = done_q;

endmodule
